// File: rtl/fpnew_pkg.sv
// Shared FP format definitions for the divsqrt datapath.
// prec_bits() gives the fraction width that the iterative engine expects on prec_i.
package fpnew_pkg;

  localparam int unsigned FP64_FRAC_BITS = 52;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // FP8 is computed through the FP16 datapath, so it uses FP16 precision.
  function automatic int unsigned prec_bits(input fp_format_e fmt);
    case (fmt)
      FP32:      return 23;
      FP64:      return 52;
      FP16, FP8: return 10;
      FP16ALT:   return 7;
      default:   return 52;
    endcase
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_iter_step.sv
// One radix-2 iteration: restoring division or digit-by-digit restoring square root.
// Purely combinational; the engine holds the partial remainder and partial result.
module fpnew_divsqrt_iter_step #(
  parameter int unsigned FracWidth = 52
) (
  input  logic                 sqrt_i,
  input  logic [FracWidth+4:0] rem_i,
  input  logic [FracWidth+2:0] quo_i,
  input  logic [FracWidth+1:0] div_i,
  input  logic [1:0]           pair_i,
  output logic [FracWidth+4:0] rem_o,
  output logic                 bit_o
);

  logic [FracWidth+2:0] dr, dd;
  logic [FracWidth+4:0] sr, trial;
  logic                 div_ge, sq_ge;

  always_comb begin
    dr     = rem_i[FracWidth+2:0];
    div_ge = dr >= {1'b0, div_i};
    dd     = div_ge ? dr - {1'b0, div_i} : dr;

    // Bring down the next radicand pair and test against 4*Q+1.
    sr     = (rem_i << 2) | {{(FracWidth+3){1'b0}}, pair_i};
    trial  = {quo_i, 2'b01};
    sq_ge  = sr >= trial;

    if (sqrt_i) begin
      bit_o = sq_ge;
      rem_o = sq_ge ? sr - trial : sr;
    end else begin
      bit_o = div_ge;
      rem_o = {1'b0, dd, 1'b0};
    end
  end

endmodule

// File: rtl/fpnew_divsqrt_iter_engine.sv
// Iterative radix-2 mantissa divide / square-root engine (one result bit per cycle).
// Responder side of the start/kill/ready/done handshake; sign/exponent handled upstream.
module fpnew_divsqrt_iter_engine
  import fpnew_pkg::*;
#(
  parameter int unsigned FracWidth = FP64_FRAC_BITS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           div_start_i,
  input  logic                           sqrt_start_i,
  input  logic                           kill_i,
  input  logic [$clog2(FracWidth+1)-1:0] prec_i,
  input  logic [FracWidth+1:0]           mant_a_i,
  input  logic [FracWidth+1:0]           mant_b_i,
  output logic                           ready_o,
  output logic                           done_o,
  output logic [FracWidth+2:0]           result_o,
  output logic                           sticky_o,
  output logic                           busy_o
);

  localparam int unsigned PW = $clog2(FracWidth+1);
  localparam int unsigned CW = $clog2(FracWidth+4);
  localparam int unsigned MW = FracWidth + 2;
  localparam int unsigned QW = FracWidth + 3;
  localparam int unsigned RW = FracWidth + 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [MW-1:0] b_q, rad_q;
  logic [QW-1:0] quo_q, res_q;
  logic [RW-1:0] rem_q;
  logic [CW-1:0] cnt_q, last_q;
  logic          sqrt_q, done_q, sticky_q;

  logic          accept;
  logic [CW-1:0] last_d;
  logic          step_sqrt, step_bit;
  logic [RW-1:0] step_rem_in, step_rem;
  logic [QW-1:0] step_quo, quo_next;
  logic [MW-1:0] step_div;
  logic [1:0]    step_pair;

  assign ready_o  = (state_q == IDLE) | (state_q == DONE);
  assign busy_o   = (state_q == RUN)  | (state_q == DONE);
  assign done_o   = done_q;
  assign result_o = res_q;
  assign sticky_o = sticky_q;

  assign accept = ready_o & (div_start_i | sqrt_start_i) & ~kill_i;

  // Iteration 0 runs in the accept cycle straight from the operand inputs,
  // so the last iteration lands in the cycle before DONE.
  always_comb begin
    last_d = (prec_i > PW'(FracWidth)) ? CW'(FracWidth + 2) : CW'(prec_i) + CW'(2);
    if (accept) begin
      step_sqrt   = ~div_start_i;
      step_rem_in = div_start_i ? {3'b000, mant_a_i} : '0;
      step_quo    = '0;
      step_div    = mant_b_i;
      step_pair   = mant_a_i[MW-1:MW-2];
    end else begin
      step_sqrt   = sqrt_q;
      step_rem_in = rem_q;
      step_quo    = quo_q;
      step_div    = b_q;
      step_pair   = rad_q[MW-1:MW-2];
    end
    quo_next = (step_quo << 1) | QW'(step_bit);
  end

  fpnew_divsqrt_iter_step #(
    .FracWidth (FracWidth)
  ) i_step (
    .sqrt_i (step_sqrt),
    .rem_i  (step_rem_in),
    .quo_i  (step_quo),
    .div_i  (step_div),
    .pair_i (step_pair),
    .rem_o  (step_rem),
    .bit_o  (step_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      b_q      <= '0;
      rad_q    <= '0;
      quo_q    <= '0;
      res_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      sqrt_q   <= 1'b0;
      done_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (accept) begin
              state_q <= RUN;
              sqrt_q  <= ~div_start_i;
              b_q     <= mant_b_i;
              rad_q   <= {mant_a_i[MW-3:0], 2'b00};
              rem_q   <= step_rem;
              quo_q   <= quo_next;
              cnt_q   <= CW'(1);
              last_q  <= last_d;
            end else begin
              state_q <= IDLE;
            end
          end
          RUN: begin
            rem_q <= step_rem;
            quo_q <= quo_next;
            rad_q <= {rad_q[MW-3:0], 2'b00};
            if (cnt_q == last_q) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              res_q    <= quo_next;
              sticky_q <= |step_rem;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpnew_divsqrt_iter_engine.sv
// Directed bench for the iterative divsqrt engine (FracWidth = 52).
// Expected quotients/roots are hand-derived bit patterns in Q1.(prec+2).
module tb_fpnew_divsqrt_iter_engine;
  import fpnew_pkg::*;

  localparam logic [53:0] ONE   = 54'h10000000000000;
  localparam logic [53:0] ONE_5 = 54'h18000000000000;
  localparam logic [53:0] TWO   = 54'h20000000000000;
  localparam logic [53:0] TWO25 = 54'h24000000000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start, sqrt_start, kill;
  logic [5:0]  prec;
  logic [53:0] ma, mb;
  logic        ready, done, sticky, busy;
  logic [54:0] result;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        d;
    logic        s;
    logic [5:0]  p;
    logic [53:0] a;
    logic [53:0] b;
    int          cyc;
    logic [54:0] res;
    logic        stk;
  } vec_t;

  always #5 clk = ~clk;

  fpnew_divsqrt_iter_engine #(.FracWidth(52)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .div_start_i  (div_start),
    .sqrt_start_i (sqrt_start),
    .kill_i       (kill),
    .prec_i       (prec),
    .mant_a_i     (ma),
    .mant_b_i     (mb),
    .ready_o      (ready),
    .done_o       (done),
    .result_o     (result),
    .sticky_o     (sticky),
    .busy_o       (busy)
  );

  task automatic start_op(input logic d, input logic s, input logic [5:0] p,
                          input logic [53:0] a, input logic [53:0] b);
    @(negedge clk);
    div_start = d; sqrt_start = s; prec = p; ma = a; mb = b;
  endtask

  // Returns the cycle (accept cycle = 0) in which done_o is seen, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin div_start = 1'b0; sqrt_start = 1'b0; end
      if (done) begin cyc = i; break; end
    end
  endtask

  task automatic run_table(input string tag, input vec_t v[], input int n);
    int cyc;
    for (int i = 0; i < n; i++) begin
      start_op(v[i].d, v[i].s, v[i].p, v[i].a, v[i].b);
      wait_done(cyc);
      compared++;
      if (cyc !== v[i].cyc) begin
        mismatched++;
        $display("FAIL %s[%0d]_latency: got %0d want %0d", tag, i, cyc, v[i].cyc);
      end
      compared++;
      if (result !== v[i].res) begin
        mismatched++;
        $display("FAIL %s[%0d]_result: got %h want %h", tag, i, result, v[i].res);
      end
      compared++;
      if (sticky !== v[i].stk) begin
        mismatched++;
        $display("FAIL %s[%0d]_sticky: got %b want %b", tag, i, sticky, v[i].stk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0;
    prec = '0; ma = '0; mb = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({ready, busy, done, sticky} !== 4'b1000 || result !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b stk=%b res=%h want 1 0 0 0 0",
               ready, busy, done, sticky, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_div;
    vec_t v[6];
    v[0] = '{1'b1, 1'b0, 6'd7,  ONE_5, ONE,   10, 55'h300, 1'b0};
    v[1] = '{1'b1, 1'b1, 6'd7,  ONE,   ONE_5, 10, 55'h155, 1'b1};
    v[2] = '{1'b1, 1'b0, 6'd0,  ONE_5, ONE,    3, 55'h6,   1'b0};
    v[3] = '{1'b1, 1'b0, 6'd0,  ONE,   ONE_5,  3, 55'h2,   1'b1};
    v[4] = '{1'b1, 1'b0, 6'(prec_bits(FP32)), ONE_5, ONE, 26, 55'h3000000, 1'b0};
    v[5] = '{1'b1, 1'b0, 6'd63, ONE_5, ONE,   55, 55'h60000000000000, 1'b0};
    run_table("div", v, 6);
  endtask

  task automatic test_sqrt;
    vec_t v[4];
    v[0] = '{1'b0, 1'b1, 6'(prec_bits(FP16ALT)), TWO25, ONE_5, 10, 55'h300, 1'b0};
    v[1] = '{1'b0, 1'b1, 6'd7, TWO, ONE, 10, 55'h2D4, 1'b1};
    v[2] = '{1'b0, 1'b1, 6'd7, ONE, TWO, 10, 55'h200, 1'b0};
    v[3] = '{1'b0, 1'b1, 6'(prec_bits(FP8)), TWO25, ONE, 13, 55'h1800, 1'b0};
    run_table("sqrt", v, 4);
  endtask

  task automatic test_start_while_busy;
    int cyc;
    cyc = -1;
    start_op(1'b1, 1'b0, 6'd7, ONE_5, ONE);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      div_start = 1'b0; sqrt_start = 1'b0;
      if (i == 3) begin
        compared++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          mismatched++;
          $display("FAIL busy_flags: got busy=%b rdy=%b want 1 0", busy, ready);
        end
        sqrt_start = 1'b1; ma = TWO;
      end
      if (done) begin cyc = i; break; end
    end
    compared++;
    if (cyc !== 10 || result !== 55'h300) begin
      mismatched++;
      $display("FAIL start_while_busy: got cyc=%0d res=%h want 10 300", cyc, result);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_op(1'b1, 1'b0, 6'd7, ONE_5, ONE);
    wait_done(cyc);
    compared++;
    if (cyc !== 10 || ready !== 1'b1 || result !== 55'h300) begin
      mismatched++;
      $display("FAIL b2b_first: got cyc=%0d rdy=%b res=%h want 10 1 300", cyc, ready, result);
    end
    sqrt_start = 1'b1; prec = 6'd7; ma = TWO; mb = ONE;
    @(negedge clk);
    sqrt_start = 1'b0;
    compared++;
    if (done !== 1'b0 || busy !== 1'b1 || result !== 55'h300) begin
      mismatched++;
      $display("FAIL b2b_accepted: got done=%b busy=%b res=%h want 0 1 300", done, busy, result);
    end
    cyc = -1;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin cyc = i; break; end
    end
    compared++;
    if (cyc !== 10 || result !== 55'h2D4 || sticky !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_second: got cyc=%0d res=%h stk=%b want 10 2d4 1", cyc, result, sticky);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_pulse_width: got done=%b rdy=%b busy=%b want 0 1 0", done, ready, busy);
    end
  endtask

  task automatic test_kill;
    int dones, cyc;
    start_op(1'b1, 1'b0, 6'd52, ONE, ONE_5);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      div_start = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    compared++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL kill_midrun: got rdy=%b busy=%b done=%b want 1 0 0", ready, busy, done);
    end
    dones = 0;
    repeat (60) begin @(negedge clk); if (done) dones++; end
    compared++;
    if (dones !== 0 || result !== 55'h2D4 || sticky !== 1'b1) begin
      mismatched++;
      $display("FAIL kill_no_done: got dones=%0d res=%h stk=%b want 0 2d4 1", dones, result, sticky);
    end
    kill = 1'b1; div_start = 1'b1; prec = 6'd7; ma = ONE_5; mb = ONE;
    @(negedge clk);
    kill = 1'b0; div_start = 1'b0;
    dones = 0;
    repeat (15) begin @(negedge clk); if (done || busy) dones++; end
    compared++;
    if (dones !== 0) begin
      mismatched++;
      $display("FAIL kill_with_start: got active_cycles=%0d want 0", dones);
    end
    start_op(1'b1, 1'b0, 6'd7, ONE, ONE_5);
    wait_done(cyc);
    kill = 1'b1; div_start = 1'b1; ma = ONE_5; mb = ONE;
    @(negedge clk);
    kill = 1'b0; div_start = 1'b0;
    compared++;
    if (cyc !== 10 || done !== 1'b0 || busy !== 1'b0 || result !== 55'h155) begin
      mismatched++;
      $display("FAIL kill_in_done: got cyc=%0d done=%b busy=%b res=%h want 10 0 0 155",
               cyc, done, busy, result);
    end
  endtask

  task automatic test_reset_midrun;
    int dones, cyc;
    start_op(1'b1, 1'b0, 6'd52, ONE_5, ONE);
    repeat (5) begin @(negedge clk); div_start = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({ready, busy, done, sticky} !== 4'b1000 || result !== '0) begin
      mismatched++;
      $display("FAIL reset_midrun: got rdy=%b busy=%b done=%b stk=%b res=%h want 1 0 0 0 0",
               ready, busy, done, sticky, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (60) begin @(negedge clk); if (done || busy) dones++; end
    compared++;
    if (dones !== 0) begin
      mismatched++;
      $display("FAIL reset_no_resume: got active_cycles=%0d want 0", dones);
    end
    start_op(1'b1, 1'b0, 6'd7, ONE_5, ONE);
    wait_done(cyc);
    compared++;
    if (cyc !== 10 || result !== 55'h300) begin
      mismatched++;
      $display("FAIL post_reset_op: got cyc=%0d res=%h want 10 300", cyc, result);
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_sqrt();
    test_start_while_busy();
    test_back_to_back();
    test_kill();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
